// File: rtl/tag_pool_pkg.sv
// Shared types and parameter checks for the tag allocator.
package tag_pool_pkg;
    localparam int TAG_POOL_W = 32;

    typedef logic [$clog2(TAG_POOL_W)-1:0] tag_t;
    typedef logic [$clog2(TAG_POOL_W):0]   count_t;

    function automatic bit w_legal(input int w);
        return (w >= 2) && ((w & (w - 1)) == 0);
    endfunction
endpackage

// File: rtl/tag_pool_find.sv
// Combinational circular zero-finder: first zero of x_i in order pos-1, pos-2, ..., pos.
module tag_pool_find #(
    parameter int W     = 32,
    parameter bit INFER = 1'b0,
    localparam int TW   = $clog2(W)
) (
    input  logic [W-1:0]  x_i,
    input  logic [TW-1:0] pos_i,
    output logic [TW-1:0] y_enc_o,
    output logic          any_o
);
    generate
        if (INFER) begin : g_rot
            // After rotating right by pos, bit i holds tag pos+i; the highest zero is the nearest below pos.
            logic [W-1:0] rot;
            assign rot = W'({x_i, x_i} >> pos_i);
            always_comb begin
                y_enc_o = '0;
                any_o   = 1'b0;
                for (int i = 0; i < W; i++) begin
                    if (!rot[i]) begin
                        y_enc_o = pos_i + TW'(i);
                        any_o   = 1'b1;
                    end
                end
            end
        end else begin : g_scan
            always_comb begin
                logic [TW-1:0] idx;
                y_enc_o = '0;
                any_o   = 1'b0;
                idx     = '0;
                for (int k = 1; k <= W; k++) begin
                    idx = pos_i - TW'(k);
                    if (!any_o && !x_i[idx]) begin
                        y_enc_o = idx;
                        any_o   = 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: rtl/tag_pool.sv
// Circular tag allocator: owns the busy vector, stages one tag on a valid/ready port, accepts frees.
module tag_pool
    import tag_pool_pkg::*;
#(
    parameter int W     = TAG_POOL_W,
    parameter bit INFER = 1'b0,
    localparam int TW   = $clog2(W),
    localparam int CW   = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          alloc_vld_o,
    output logic [TW-1:0] alloc_tag_o,
    input  logic          alloc_rdy_i,
    input  logic          free_vld_i,
    input  logic [TW-1:0] free_tag_i,
    output logic [W-1:0]  busy_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          err_o
);
    generate
        if (!w_legal(W)) begin : g_bad_w
            $error("tag_pool: W must be a power of two and >= 2");
        end
    endgenerate

    logic [W-1:0]  busy_q;
    logic [TW-1:0] ptr_q;
    logic          out_vld_q;
    logic [TW-1:0] out_tag_q;
    logic [CW-1:0] count_q;
    logic          err_q;

    logic [TW-1:0] cand;
    logic          any;

    tag_pool_find #(.W(W), .INFER(INFER)) u_find (
        .x_i     (busy_q),
        .pos_i   (ptr_q),
        .y_enc_o (cand),
        .any_o   (any)
    );

    logic load, accept, staged_hit, legal_free;

    assign load       = (~out_vld_q | alloc_rdy_i) & any;
    assign accept     = out_vld_q & alloc_rdy_i;
    // A staged tag is not yet owned by anyone downstream, so it cannot be returned.
    assign staged_hit = out_vld_q & (out_tag_q == free_tag_i);
    assign legal_free = free_vld_i & busy_q[free_tag_i] & ~staged_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            ptr_q     <= '0;
            out_vld_q <= 1'b0;
            out_tag_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            // The freed bit was busy and the candidate was free, so these never collide.
            if (legal_free) busy_q[free_tag_i] <= 1'b0;
            if (load) begin
                busy_q[cand] <= 1'b1;
                ptr_q        <= cand;
                out_tag_q    <= cand;
                out_vld_q    <= 1'b1;
            end else if (accept) begin
                out_vld_q    <= 1'b0;
            end
            count_q <= count_q + CW'(load) - CW'(legal_free);
            if (free_vld_i && !legal_free) err_q <= 1'b1;
        end
    end

    assign alloc_vld_o = out_vld_q;
    assign alloc_tag_o = out_tag_q;
    assign busy_o      = busy_q;
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(W));
    assign err_o       = err_q;
endmodule

// File: tb/tb_tag_pool.sv
// Bench for tag_pool: vector table, directed corner sequences, and random traffic vs a reference model.
module tb_tag_pool;
    import tag_pool_pkg::*;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, alloc_rdy, free_vld;
    tag_t         free_tag;
    logic         alloc_vld, full, err;
    tag_t         alloc_tag;
    logic [W-1:0] busy;
    count_t       count;

    int checks = 0;
    int failures = 0;

    tag_pool #(.W(W), .INFER(1'b0)) dut (
        .clk(clk), .rst(rst),
        .alloc_vld_o(alloc_vld), .alloc_tag_o(alloc_tag), .alloc_rdy_i(alloc_rdy),
        .free_vld_i(free_vld), .free_tag_i(free_tag),
        .busy_o(busy), .count_o(count), .full_o(full), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model: set of busy tags, pointer, staged slot, sticky error.
    bit [W-1:0] m_busy;
    int         m_ptr, m_tag;
    bit         m_vld, m_err;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update();
        int  cand;
        bit  found, legal;
        if (rst) begin
            m_busy = '0; m_ptr = 0; m_tag = 0; m_vld = 0; m_err = 0;
            return;
        end
        found = 0; cand = 0;
        for (int k = 1; k <= W; k++) begin
            int t = (m_ptr - k + W) % W;
            if (!found && !m_busy[t]) begin cand = t; found = 1; end
        end
        legal = free_vld && m_busy[free_tag] && !(m_vld && m_tag == int'(free_tag));
        if (free_vld && !legal) m_err = 1;
        if (legal) m_busy[free_tag] = 0;
        if ((!m_vld || alloc_rdy) && found) begin
            m_busy[cand] = 1; m_ptr = cand; m_tag = cand; m_vld = 1;
        end else if (m_vld && alloc_rdy) begin
            m_vld = 0;
        end
    endtask

    // One clock: model advances with the inputs seen at the edge, then DUT is compared to it.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model_vld",   alloc_vld, m_vld);
        check("model_tag",   alloc_tag, m_tag);
        check("model_busy",  busy, m_busy);
        check("model_count", count, $countones(m_busy));
        check("model_full",  full, $countones(m_busy) == W);
        check("model_err",   err, m_err);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic fv, input int ft);
        rst = r; alloc_rdy = rdy; free_vld = fv; free_tag = tag_t'(ft);
    endtask

    typedef struct {
        logic rst, rdy, fv;
        int   ftag;
        logic e_vld;
        int   e_tag, e_cnt;
        logic e_err;
    } vec_t;
    vec_t tbl[10];

    initial begin
        drive(1, 0, 0, 0);

        // rst rdy fv ftag | vld tag cnt err
        tbl[0] = '{1, 0, 0,  0, 0,  0, 0, 0};
        tbl[1] = '{0, 0, 0,  0, 1, 31, 1, 0};
        tbl[2] = '{0, 0, 0,  0, 1, 31, 1, 0};
        tbl[3] = '{0, 1, 0,  0, 1, 30, 2, 0};
        tbl[4] = '{0, 0, 1, 31, 1, 30, 1, 0};
        tbl[5] = '{0, 0, 1, 30, 1, 30, 1, 1};
        tbl[6] = '{0, 0, 1,  7, 1, 30, 1, 1};
        tbl[7] = '{1, 1, 0,  0, 0,  0, 0, 0};
        tbl[8] = '{0, 1, 0,  0, 1, 31, 1, 0};
        tbl[9] = '{0, 1, 0,  0, 1, 30, 2, 0};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].fv, tbl[i].ftag);
            step();
            check($sformatf("tbl%0d_vld", i), alloc_vld, tbl[i].e_vld);
            check($sformatf("tbl%0d_tag", i), alloc_tag, tbl[i].e_tag);
            check($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
            check($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
        end

        // Reset, full-speed stream of all tags in descending order.
        drive(1, 1, 0, 0); step();
        check("reset_busy", busy, 0);
        check("reset_vld", alloc_vld, 0);
        drive(0, 1, 0, 0);
        for (int i = 0; i < W; i++) begin
            step();
            check($sformatf("stream_tag%0d", i), alloc_tag, W - 1 - i);
            check($sformatf("stream_vld%0d", i), alloc_vld, 1);
            check($sformatf("stream_cnt%0d", i), count, i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("empty_vld", alloc_vld, 0);
            check("empty_full", full, 1);
            check("empty_cnt", count, W);
        end

        // Free while full: tag 5 reappears two cycles after the free is presented.
        drive(0, 1, 1, 5); step();
        check("ff_cnt_dip", count, W - 1);
        check("ff_busy5", busy[5], 0);
        drive(0, 1, 0, 0); step();
        check("ff_vld", alloc_vld, 1);
        check("ff_tag", alloc_tag, 5);
        check("ff_cnt", count, W);
        step();
        check("ff_drain_vld", alloc_vld, 0);

        // Backpressure after the first load.
        drive(1, 0, 0, 0); step();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_tag", alloc_tag, 31);
            check("bp_cnt", count, 1);
        end
        drive(0, 1, 0, 0); step();
        check("bp_release_tag", alloc_tag, 30);

        // Accept and free together: consumer-held 31 returns as 30 is accepted.
        drive(0, 1, 1, 31); step();
        check("af_cnt", count, 2);
        check("af_busy31", busy[31], 0);
        check("af_tag", alloc_tag, 29);
        check("af_err", err, 0);
        // Freeing the tag being accepted this cycle is illegal.
        drive(0, 1, 1, 29); step();
        check("af_staged_err", err, 1);
        check("af_staged_busy", busy[29], 1);

        // Reset mid-operation with a tag staged.
        drive(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step();
        drive(0, 0, 0, 0); step();
        drive(1, 0, 0, 0); step();
        check("rmid_vld", alloc_vld, 0);
        check("rmid_busy", busy, 0);
        check("rmid_cnt", count, 0);
        check("rmid_err", err, 0);
        drive(0, 1, 0, 0); step();
        check("rmid_first", alloc_tag, 31);

        // Random traffic; frees favour tags the model believes are busy.
        for (int i = 0; i < 800; i++) begin
            int ft;
            ft = $urandom_range(W - 1);
            if ($urandom_range(3) != 0) begin
                for (int k = 0; k < W; k++)
                    if (m_busy[(ft + k) % W]) begin ft = (ft + k) % W; break; end
            end
            drive($urandom_range(60) == 0, $urandom_range(9) < 6,
                  $urandom_range(9) < 4, ft);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
